mem_port_arbiter: RTL

//   Shares the single Main_Memory port between the instruction-fetch requester (Control/PC) and the

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 19 +
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids and a state helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // The memory strobes are driven only while a transaction is on the bus.
    function automatic logic is_active(state_t s);
        return (s == ST_ISSUE) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way alternating-priority picker: on a tie the port that was not served last wins.
module rr_pick2 (
    input  logic req_fetch,
    input  logic req_data,
    input  logic last_data,
    output logic valid,
    output logic grant_data
);

    always_comb begin
        valid = req_fetch | req_data;
        if (req_fetch && req_data) begin
            grant_data = ~last_data;
        end else begin
            grant_data = req_data;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Main_Memory port between instruction fetch and the load/store path.
// Optional watchdog on the WAIT phase is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW             = 13,
    parameter int DW             = 13,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TW             = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_dataIn,
    output logic          mem_write,
    output logic          mem_read,
    output logic          mem_instr,
    input  logic [DW-1:0] mem_dataOut,
    input  logic          mem_done
);

    if (TIMEOUT_CYCLES >= (1 << TW)) begin : g_tw_check
        $error("TW is too narrow to hold TIMEOUT_CYCLES");
    end

    state_t        state_q, state_d;
    port_t         grant_q, grant_d;
    port_t         last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          pick_valid, pick_data;
    logic          active;
    logic          timeout;

    rr_pick2 u_pick (
        .req_fetch (if_req),
        .req_data  (d_req),
        .last_data (last_q == PORT_DATA),
        .valid     (pick_valid),
        .grant_data(pick_data)
    );

    assign active = is_active(state_q);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo_q, tmo_d;

    assign timeout = active && !mem_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (active && !mem_done) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = port_t'(pick_data);
                    addr_d  = pick_data ? d_addr : if_addr;
                    we_d    = pick_data & d_we;
                    wdata_d = pick_data ? d_wdata : '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (mem_done) begin
                    state_d = ST_RESP;
                    if (grant_q == PORT_FETCH) begin
                        if_rdata_d = mem_dataOut;
                    end else begin
                        d_rdata_d = we_q ? '0 : mem_dataOut;
                    end
                end else if (timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    if (grant_q == PORT_FETCH) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= PORT_FETCH;
            last_q     <= PORT_DATA;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes are decoded from registered state only, so reset clears them at once.
    assign mem_address = active ? addr_q : '0;
    assign mem_dataIn  = (active && we_q) ? wdata_q : '0;
    assign mem_write   = active && we_q;
    assign mem_read    = active && !we_q;
    assign mem_instr   = active && (grant_q == PORT_FETCH);
    assign if_ack      = (state_q == ST_RESP) && (grant_q == PORT_FETCH);
    assign d_ack       = (state_q == ST_RESP) && (grant_q == PORT_DATA);
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign err         = err_q;

endmodule
